trade_sequencer: RTL
====================

# trade_sequencer

Sequencing controller between order intake, the matching engine and the trade counter. It accepts one order at a time with a valid/ready handshake and pulses the engine's load and start strobes. When the engine reports an executed trade, it issues the single-cycle `enable_count` pulse to the trade counter. On the counter's `halt_flag` it parks the system in HALT and stops accepting orders; it also aborts any match that never completes.

## Interface
- `MATCH_TIMEOUT`, default 8'd16: cycles allowed in WAIT without `match_done` before abort; legal range 1..255.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `order_valid`  in  1  order available from intake.
- `order_ready`  out  1  controller accepts; transfer when `order_valid && order_ready`.
- `load_order`  out  1  one-cycle strobe: matching engine latches the order.
- `match_start`  out  1  one-cycle strobe: matching engine begins evaluation.
- `match_done`  in  1  engine finished; qualifies `match_flag`.
- `match_flag`  in  1  trade executed; sampled only with `match_done` in WAIT.
- `enable_count`  out  1  one-cycle strobe to trade counter.
- `halt_flag`  in  1  trade-limit reached, from trade counter.
- `busy`  out  1  high in LOAD, START, WAIT, COMMIT.
- `timeout_err`  out  1  sticky; set on match abort, cleared only by reset.
- `state`  out  3  current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, LOAD=1, START=2, WAIT=3, COMMIT=4, HALT=5. Codes 6 and 7 go to IDLE on the next edge.
- Outputs are Moore, decoded from the registered state. `timeout_err` is a register.
  - `order_ready` = (IDLE && !halt_flag).
  - `load_order` = LOAD; `match_start` = START; `enable_count` = COMMIT.
- IDLE:
  - `halt_flag` → HALT. Halt has priority over `order_valid` in the same cycle; no handshake occurs.
  - Otherwise `order_valid` → LOAD; else stay in IDLE.
- LOAD → START unconditionally.
- START → WAIT unconditionally; clears the 8-bit wait timer to 0.
- WAIT:
  - `match_done && match_flag` → COMMIT.
  - `match_done && !match_flag` → IDLE, with no count.
  - No `match_done` and timer == MATCH_TIMEOUT-1 → IDLE; set `timeout_err`; no count.
  - Otherwise timer increments and the block stays in WAIT.
  - `match_done` wins over timeout in the same cycle.
- COMMIT → IDLE unconditionally.
- HALT: absorbing. All strobes are 0, `order_ready` = 0, `busy` = 0. Only reset exits HALT.
- `halt_flag` asserting in LOAD/START/WAIT/COMMIT does not abort the transaction in flight; it takes effect on the next IDLE cycle.
- `match_done` and `match_flag` are ignored outside WAIT.
- `order_valid` is ignored outside IDLE.

## Timing
- Reset values (cycle after `reset` is sampled high):
  - state = IDLE, timer = 0, `timeout_err` = 0.
  - `load_order`, `match_start`, `enable_count`, `busy` = 0.
  - `order_ready` = !halt_flag.
- Reset asserted in any state, including mid-WAIT or HALT, forces IDLE on that edge. No strobe is issued in the following cycle.
- Handshake at cycle N (IDLE):
  - `load_order` high at N+1.
  - `match_start` high at N+2.
  - WAIT from N+3.
  - Earliest `match_done` is sampled at N+3.
- `match_done && match_flag` sampled at cycle M:
  - `enable_count` high during M+1 only; the counter increments at the end of M+1.
  - `order_ready` earliest at M+2.
- Minimum order-to-order spacing is 5 cycles (IDLE, LOAD, START, WAIT, COMMIT). It is 4 cycles for a no-match.
- Timeout: with no `match_done`, WAIT lasts exactly MATCH_TIMEOUT cycles.
  - `timeout_err` rises and the state is IDLE on the following cycle.
  - With MATCH_TIMEOUT=1, WAIT lasts 1 cycle.
- At most one `enable_count` pulse per accepted order. `enable_count` is never high in two consecutive cycles.

## Test plan
- Reset: hold `reset` 2 cycles with random inputs → state=0, all strobes 0, `timeout_err`=0, `order_ready`=1 while `halt_flag`=0.
- Match path: `order_valid` at N with `match_done`=`match_flag`=1 at N+5 → `load_order` at N+1, `match_start` at N+2, `enable_count` only at N+6, `order_ready` again at N+7.
- No-match: `match_done`=1, `match_flag`=0 in WAIT → back to IDLE next cycle; `enable_count` never asserted; `match_flag` pulsed during IDLE/LOAD is also ignored.
- Timeout, MATCH_TIMEOUT=4: no `match_done` → exactly 4 WAIT cycles, then IDLE with `timeout_err`=1 persisting through later orders. A second run with `match_done` on the 4th WAIT cycle → COMMIT, `timeout_err` stays 0.
- Halt priority:
  - `halt_flag`=1 and `order_valid`=1 in the same IDLE cycle → no handshake, HALT next cycle; stays there for 20 cycles of `order_valid`.
  - `halt_flag` asserted during WAIT → the transaction completes (COMMIT), then HALT.
- Reset mid-operation: `reset` during WAIT at timer=2 → IDLE next cycle, no `enable_count`. A new order then completes normally with timer restarting from 0.

Source files
------------

// File: rtl/trade_sequencer_if.sv
// Handshake and strobe bundle between the trade sequencer and its neighbours
// (order intake, matching engine, trade counter).
interface trade_sequencer_if;
   logic       order_valid;
   logic       order_ready;
   logic       load_order;
   logic       match_start;
   logic       match_done;
   logic       match_flag;
   logic       enable_count;
   logic       halt_flag;
   logic       busy;
   logic       timeout_err;
   logic [2:0] state;

   // Sequencer side drives strobes and status.
   modport master (
      input  order_valid, match_done, match_flag, halt_flag,
      output order_ready, load_order, match_start, enable_count,
             busy, timeout_err, state
   );

   // Environment side: intake, engine and counter.
   modport slave (
      output order_valid, match_done, match_flag, halt_flag,
      input  order_ready, load_order, match_start, enable_count,
             busy, timeout_err, state
   );
endinterface

// File: rtl/trade_sequencer.sv
// Order sequencing controller: accepts one order, strobes the matching engine,
// pulses the trade counter on an executed trade, and parks in HALT on limit.
module trade_sequencer #(
   parameter logic [7:0] MATCH_TIMEOUT = 8'd16
) (
   input  logic                clk,
   input  logic                reset,
   trade_sequencer_if.master   bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      START  = 3'd2,
      WAIT   = 3'd3,
      COMMIT = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [7:0] TIMER_LAST = MATCH_TIMEOUT - 8'd1;

   state_t     state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic       timeout_err_q, timeout_err_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         timer_q       <= 8'd0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         IDLE: begin
            // Halt outranks a pending order; no handshake happens that cycle.
            if (bus.halt_flag)
               state_d = HALT;
            else if (bus.order_valid)
               state_d = LOAD;
         end
         LOAD:   state_d = START;
         START: begin
            state_d = WAIT;
            timer_d = 8'd0;
         end
         WAIT: begin
            // A completion in the final timer cycle still counts.
            if (bus.match_done)
               state_d = bus.match_flag ? COMMIT : IDLE;
            else if (timer_q == TIMER_LAST) begin
               state_d       = IDLE;
               timeout_err_d = 1'b1;
            end else
               timer_d = timer_q + 8'd1;
         end
         COMMIT: state_d = IDLE;
         HALT:   state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   assign bus.order_ready  = (state_q == IDLE) && !bus.halt_flag;
   assign bus.load_order   = (state_q == LOAD);
   assign bus.match_start  = (state_q == START);
   assign bus.enable_count = (state_q == COMMIT);
   assign bus.busy         = (state_q == LOAD) || (state_q == START) ||
                             (state_q == WAIT) || (state_q == COMMIT);
   assign bus.timeout_err  = timeout_err_q;
   assign bus.state        = state_q;

endmodule
